// File: rtl/ram_fifo_rx.sv
// First-word-fall-through FIFO on an inferred simple dual-port RAM plus output register; write->m_valid = 2 edges.
// s_ready is (count != DEPTH) only, so a full FIFO refuses writes even while a read is accepted.
module ram_fifo_rx #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 9,
  parameter int AFULL_THRESH = 2**AWIDTH - 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [AWIDTH:0]   count,
  output logic              almost_full,
  output logic              overflow
);

  localparam logic [AWIDTH:0] DEPTH_C = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] ONE_C   = {{AWIDTH{1'b0}}, 1'b1};
  localparam int              AF_I    = AFULL_THRESH;
  localparam logic [AWIDTH:0] AF_C    = AF_I[AWIDTH:0];

  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [DWIDTH-1:0] ram_q;
  logic              q_vld;
  logic [AWIDTH:0]   ram_cnt;
  logic [AWIDTH:0]   count_nxt;
  logic              active;
  logic              wr_en;
  logic              rd_en;
  logic              out_load;
  logic              ram_rd;

  assign active   = enable & ~flush & ~reset;
  assign s_ready  = (count != DEPTH_C);
  assign wr_en    = active & s_valid & s_ready;
  assign rd_en    = active & m_valid & m_ready;
  assign out_load = active & (~m_valid | m_ready);

  // Words still in the array: total occupancy minus the two pipeline stages.
  assign ram_cnt  = count - {{AWIDTH{1'b0}}, q_vld} - {{AWIDTH{1'b0}}, m_valid};
  assign ram_rd   = active & (ram_cnt != '0) & (~q_vld | out_load);

  always_comb begin
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
  end

  // Array and its registered read port carry no reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= s_data;
    if (ram_rd) ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_vld       <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_vld       <= 1'b0;
      m_valid     <= 1'b0;
      count       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else if (enable) begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (ram_rd) rd_ptr <= rd_ptr + 1'b1;
      q_vld <= ram_rd | (q_vld & ~out_load);
      if (out_load) begin
        m_valid <= q_vld;
        if (q_vld) m_data <= ram_q;
      end
      count       <= count_nxt;
      almost_full <= (count_nxt >= AF_C);
      if (s_valid & ~s_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_fifo_rx.sv
// Directed bench for ram_fifo_rx: queue-level occupancy model compared every cycle,
// plus hand-computed literal expectations for latency, full/overflow, enable and flush/reset.
module tb_ram_fifo_rx;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          flush;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW:0]   count;
  logic          almost_full;
  logic          overflow;

  ram_fifo_rx #(.DWIDTH(DW), .AWIDTH(AW), .AFULL_THRESH(AFT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int            n_chk = 0;
  int            n_fail = 0;
  bit            check_en = 1'b0;
  logic [DW-1:0] mq[$];
  bit            m_ovf = 1'b0;
  logic [DW-1:0] rx_log[$];
  bit            rx_en = 1'b0;
  bit            mdl_rd;
  bit            mdl_wr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Queue model: the FIFO is just an ordered list of accepted words.
  always @(posedge clock) begin
    if (reset || flush) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (enable) begin
      mdl_rd = m_valid && m_ready;
      mdl_wr = s_valid && (mq.size() < DEPTH);
      if (s_valid && mq.size() == DEPTH) m_ovf = 1'b1;
      if (mdl_rd && mq.size() > 0) begin
        if (rx_en) rx_log.push_back(m_data);
        void'(mq.pop_front());
      end
      if (mdl_wr) mq.push_back(s_data);
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      check("count_vs_model", count, mq.size());
      check("s_ready_vs_model", s_ready, mq.size() != DEPTH);
      check("almost_full_vs_model", almost_full, mq.size() >= AFT);
      check("overflow_vs_model", overflow, m_ovf);
      if (mq.size() == 0) check("m_valid_when_empty", m_valid, 1'b0);
      else if (m_valid) check("m_data_head", m_data, mq[0]);
    end
  end

  task automatic wait_mvalid(input int budget);
    int k;
    k = 0;
    while (!m_valid && k < budget) begin
      tick();
      k++;
    end
    check("wait_m_valid", m_valid, 1'b1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int wi;
    int maxc;
    int cyc;
    bit acc;

    reset = 1'b1; enable = 1'b1; flush = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_en = 1'b1;
    check("rst_count", count, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_almost_full", almost_full, 0);
    check("rst_overflow", overflow, 0);

    // Single word latency: visible exactly two edges after the write edge.
    s_valid = 1'b1; s_data = 32'hA5;
    tick();
    s_valid = 1'b0;
    check("lat_after_n", m_valid, 0);
    tick();
    check("lat_after_n1", m_valid, 0);
    tick();
    check("lat_after_n2_valid", m_valid, 1);
    check("lat_after_n2_data", m_data, 32'hA5);
    check("lat_after_n2_count", count, 1);
    do_flush();

    // Fill to full with no reads.
    for (int k = 0; k < DEPTH; k++) begin
      s_valid = 1'b1; s_data = k;
      tick();
      check("fill_count", count, k + 1);
      check("fill_almost_full", almost_full, (k + 1) >= 12);
    end
    check("full_s_ready", s_ready, 0);
    check("full_count", count, 16);
    s_data = 32'h99;
    tick();
    s_valid = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    check("ovf_head", m_data, 0);

    // Full: simultaneous read and write -> only the read happens.
    m_ready = 1'b1; s_valid = 1'b1; s_data = 32'h77;
    tick();
    m_ready = 1'b0; s_valid = 1'b0;
    check("rw_full_count", count, 15);
    check("rw_full_s_ready", s_ready, 1);
    check("rw_full_m_valid", m_valid, 1);
    check("rw_full_next_head", m_data, 1);
    check("ovf_sticky", overflow, 1);
    do_flush();
    check("flush_ovf_clear", overflow, 0);
    check("flush_count", count, 0);

    // Streaming through two pointer wraps.
    wi = 0; maxc = 0; cyc = 0;
    rx_en = 1'b1;
    while (rx_log.size() < 40 && cyc < 200) begin
      s_valid = (wi < 40); s_data = wi; m_ready = 1'b1;
      acc = s_valid && s_ready;
      tick();
      if (acc) wi++;
      if (int'(count) > maxc) maxc = int'(count);
      cyc++;
    end
    rx_en = 1'b0;
    s_valid = 1'b0; m_ready = 1'b0;
    check("stream_rx_count", rx_log.size(), 40);
    for (int i = 0; i < rx_log.size() && i < 40; i++) check("stream_order", rx_log[i], i);
    check("stream_max_count_le3", maxc <= 3, 1);
    tick(); tick();

    // Enable low freezes everything despite traffic.
    for (int k = 0; k < 7; k++) begin
      s_valid = 1'b1; s_data = 32'h100 + k;
      tick();
    end
    s_valid = 1'b0;
    tick(); tick(); tick();
    check("pre_hold_count", count, 7);
    check("pre_hold_head", m_data, 32'h100);
    enable = 1'b0; s_valid = 1'b1; m_ready = 1'b1; s_data = 32'hDEAD;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_count", count, 7);
      check("hold_m_valid", m_valid, 1);
      check("hold_m_data", m_data, 32'h100);
    end
    enable = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    tick();
    check("resume_count", count, 7);

    // Flush beats a concurrent write.
    flush = 1'b1; s_valid = 1'b1; s_data = 32'hBEEF;
    tick();
    flush = 1'b0; s_valid = 1'b0;
    check("flush7_count", count, 0);
    check("flush7_m_valid", m_valid, 0);
    check("flush7_overflow", overflow, 0);
    check("flush7_s_ready", s_ready, 1);
    tick(); tick(); tick();
    check("flush7_dropped", m_valid, 0);

    // Reset mid-stream.
    for (int k = 0; k < 9; k++) begin
      s_valid = 1'b1; s_data = 32'h200 + k;
      tick();
    end
    s_valid = 1'b0;
    tick(); tick();
    check("pre_rst_count", count, 9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_almost_full", almost_full, 0);
    check("midrst_overflow", overflow, 0);
    s_valid = 1'b1; s_data = 32'h3C;
    tick();
    s_data = 32'h3D;
    tick();
    s_valid = 1'b0;
    wait_mvalid(10);
    check("post_rst_first", m_data, 32'h3C);
    m_ready = 1'b1;
    tick(); tick(); tick();
    m_ready = 1'b0;
    check("post_rst_drained", count, 0);
    tick();

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_fifo_rx.md
RAM_FIFO_RX -- requirements
Module: ram_fifo_rx

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, meaning the data word width in bits.
REQ-002 The block SHALL have parameter AWIDTH, default 9, meaning log2 of capacity, so DEPTH = 2^AWIDTH words.
REQ-003 The block SHALL have parameter AFULL_THRESH, default 2^AWIDTH-4, meaning the occupancy at or above which almost_full is asserted.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock for all logic.
REQ-005 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit; when 0, all state is frozen.
REQ-007 The block SHALL have port flush, input, 1 bit, a synchronous discard of all contents.
REQ-008 The block SHALL have port s_data, input, DWIDTH bits, the write data.
REQ-009 The block SHALL have port s_valid, input, 1 bit, the write request.
REQ-010 The block SHALL have port s_ready, output, 1 bit, meaning space is available.
REQ-011 The block SHALL have port m_data, output, DWIDTH bits, the head-of-queue data.
REQ-012 The block SHALL have port m_valid, output, 1 bit, meaning m_data is valid.
REQ-013 The block SHALL have port m_ready, input, 1 bit, the consumer accept.
REQ-014 The block SHALL have port count, output, AWIDTH+1 bits, the total occupancy (0..DEPTH).
REQ-015 The block SHALL have ports almost_full and overflow, outputs, 1 bit each.

Function
REQ-016 Storage SHALL be an inferred simple dual-port RAM with a registered read plus one output register; total capacity SHALL be DEPTH words, including the output register.
REQ-017 The block SHALL operate first-word-fall-through: the head word SHALL be presented on m_data while m_valid=1, with no read strobe needed.
REQ-018 A write SHALL occur on a clock edge with enable & s_valid & s_ready & !flush; a read SHALL occur on enable & m_valid & m_ready & !flush.
REQ-019 s_ready SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on m_ready, so a write to a full FIFO is refused even when a read occurs in the same cycle.
REQ-020 Latency SHALL be as follows: a word written at edge N into an empty FIFO SHALL appear with m_valid=1 after edge N+2, and no earlier.
REQ-021 After a read, the next stored word SHALL be presented after at most 2 edges; back-to-back reads SHALL sustain 1 word per cycle once the pipeline is primed.
REQ-022 count SHALL be +1 on a write only, -1 on a read only, and unchanged on a simultaneous read and write or when neither occurs.
REQ-023 Read and write pointers SHALL be AWIDTH bits and SHALL wrap modulo DEPTH with no gap or skip at the wrap boundary.
REQ-024 almost_full SHALL be registered and SHALL equal (count >= AFULL_THRESH), reflecting count after the same edge.
REQ-025 overflow SHALL set on an edge with enable & s_valid & !s_ready, and SHALL remain sticky until flush or reset.
REQ-026 Underflow SHALL be impossible, because reads are qualified by m_valid.
REQ-027 When enable=0, no write, read, pointer or count change SHALL occur, and m_valid and m_data SHALL hold.
REQ-028 flush SHALL take priority over enable and over any concurrent write or read.
REQ-029 On flush, after the edge: count=0, m_valid=0, pointers=0, overflow=0, almost_full=0, s_ready=1; the data in the flush cycle SHALL be dropped.
REQ-030 m_data SHALL be held stable while m_valid=1 and m_ready=0.

Reset
REQ-031 On reset=1 at an edge, the block SHALL apply the flush state and set m_data=0; reset SHALL override enable and flush.
REQ-032 Reset asserted mid-stream SHALL discard all contents, and the first word written after release SHALL be the first word read.
REQ-033 RAM contents SHALL need no reset; the initial value of all registers SHALL equal their reset value.

Verification (AWIDTH=4, DEPTH=16, AFULL_THRESH=12)
REQ-034 Bench SHALL cover: reset, then write 0xA5 once with m_ready=0 -> m_valid=1 exactly 2 edges later, m_data=0xA5, count=1.
REQ-035 Bench SHALL cover: write 16 words 0..15 with m_ready=0 -> s_ready=0 and count=16 after the 16th write, almost_full rising as count goes 11 to 12; a 17th s_valid -> overflow=1 with contents unchanged.
REQ-036 Bench SHALL cover: 40 words streamed with s_valid and m_ready held high -> output is 0..39 in order with no duplicates across 2 pointer wraps, and count stays at or below 3.
REQ-037 Bench SHALL cover: FIFO full, then m_ready=1 and s_valid=1 in the same cycle -> read accepted, write refused, count=15, s_ready=1 on the next cycle.
REQ-038 Bench SHALL cover: enable=0 for 5 cycles with traffic applied -> count, m_data and m_valid unchanged; flush with count=7 and s_valid=1 -> count=0, m_valid=0, overflow=0.
REQ-039 Bench SHALL cover: reset pulsed with count=9 -> all outputs return to reset values in 1 edge, and the next write of 0x3C is read first.
